// File: rtl/mat_mul_result_drain.sv
// Result-side consumer for mat_mul: captures a whole C matrix, then streams it
// out row-major as tagged valid/ready words and counts completed matrices.
module mat_mul_result_drain #(
   parameter int  DATA_WIDTH = 32,
   parameter int  ROWS_A     = 3,
   parameter int  COLS_B     = 1,
   parameter int  CNT_WIDTH  = 16,
   localparam int RW         = (ROWS_A > 1) ? $clog2(ROWS_A) : 1,
   localparam int CW         = (COLS_B > 1) ? $clog2(COLS_B) : 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  out_valid,
   input  logic [DATA_WIDTH-1:0] c [ROWS_A][COLS_B],
   output logic                  out_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [RW-1:0]         m_row,
   output logic [CW-1:0]         m_col,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  mat_count,
   output logic                  busy
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND} state_t;

   state_t                  state_q, state_d;
   logic                    out_ready_q, out_ready_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic [RW-1:0]           m_row_q, m_row_d;
   logic [CW-1:0]           m_col_q, m_col_d;
   logic [CNT_WIDTH-1:0]    mat_count_q, mat_count_d;
   logic [DATA_WIDTH-1:0]   buf_q [ROWS_A][COLS_B];
   logic [RW-1:0]           row_nx;
   logic [CW-1:0]           col_nx;
   logic                    capture;

   assign capture = (state_q == ST_IDLE) && out_valid;

   // Holding buffer needs no reset: it is only read after a capture fills it.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_q <= c;
      end
   end

   // Row-major successor of the word currently on the stream.
   always_comb begin
      row_nx = m_row_q;
      col_nx = m_col_q + CW'(1);
      if (m_col_q == CW'(COLS_B - 1)) begin
         col_nx = '0;
         row_nx = m_row_q + RW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      out_ready_d = out_ready_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      m_data_d    = m_data_q;
      m_row_d     = m_row_q;
      m_col_d     = m_col_q;
      mat_count_d = mat_count_q;
      case (state_q)
         ST_INIT: begin
            state_d     = ST_IDLE;
            out_ready_d = 1'b1;
         end
         ST_IDLE: begin
            if (out_valid) begin
               state_d     = ST_SEND;
               out_ready_d = 1'b0;
               m_valid_d   = 1'b1;
               m_data_d    = c[0][0];
               m_row_d     = '0;
               m_col_d     = '0;
               m_last_d    = (ROWS_A * COLS_B == 1);
            end
         end
         ST_SEND: begin
            if (m_ready) begin
               if (m_last_q) begin
                  state_d     = ST_IDLE;
                  out_ready_d = 1'b1;
                  m_valid_d   = 1'b0;
                  m_last_d    = 1'b0;
                  mat_count_d = mat_count_q + CNT_WIDTH'(1);
               end else begin
                  m_row_d  = row_nx;
                  m_col_d  = col_nx;
                  m_data_d = buf_q[row_nx][col_nx];
                  m_last_d = (row_nx == RW'(ROWS_A - 1)) && (col_nx == CW'(COLS_B - 1));
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_INIT;
         out_ready_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
         m_row_q     <= '0;
         m_col_q     <= '0;
         mat_count_q <= '0;
      end else begin
         state_q     <= state_d;
         out_ready_q <= out_ready_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
         m_row_q     <= m_row_d;
         m_col_q     <= m_col_d;
         mat_count_q <= mat_count_d;
      end
   end

   assign out_ready = out_ready_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign m_data    = m_data_q;
   assign m_row     = m_row_q;
   assign m_col     = m_col_q;
   assign mat_count = mat_count_q;
   assign busy      = (state_q == ST_SEND);

endmodule
